// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates an instruction-fetch port (IC) and a data port (DC)
// onto one byte-wide synchronous RAM. Multi-byte accesses are sequenced one
// byte per cycle, little-endian.
//
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   en                  global enable, 0 stalls issue, accept and read completion
//   iIC_En/iIC_Add      fetch request (level) and base address
//   iIC_Clr             abort an in-flight fetch, masks IC arbitration in IDLE
//   oIC_En/oIC_Dat      fetch done pulse and fetched bytes
//   iDC_En/iDC_Rw       data request (level), 1 = read, 0 = write
//   iDC_Len             0 = 1 byte, 1 = 2 bytes, 2/3 = DC_BYTES
//   iDC_Add/iDC_Dat     data base address and write data
//   oDC_En/oDC_Dat      data done pulse and read data (zero-extended)
//   oRAM_Rw/oRAM_Add    RAM direction (1 = read) and byte address
//   oRAM_Dat/iRAM_Dat   RAM write byte / read byte (valid one cycle after address)
//   oBusy               high whenever a transaction is in progress
module mem_arb_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int RAM_ADDR_W = 17,
    parameter int BYTE_W     = 8,
    parameter int IC_BYTES   = 4,
    parameter int DC_BYTES   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         iIC_En,
    input  logic [ADDR_W-1:0]            iIC_Add,
    input  logic                         iIC_Clr,
    output logic                         oIC_En,
    output logic [IC_BYTES*BYTE_W-1:0]   oIC_Dat,
    input  logic                         iDC_En,
    input  logic                         iDC_Rw,
    input  logic [1:0]                   iDC_Len,
    input  logic [ADDR_W-1:0]            iDC_Add,
    input  logic [DC_BYTES*BYTE_W-1:0]   iDC_Dat,
    output logic                         oDC_En,
    output logic [DC_BYTES*BYTE_W-1:0]   oDC_Dat,
    output logic                         oRAM_Rw,
    output logic [RAM_ADDR_W-1:0]        oRAM_Add,
    output logic [BYTE_W-1:0]            oRAM_Dat,
    input  logic [BYTE_W-1:0]            iRAM_Dat,
    output logic                         oBusy
);

    localparam int MAXB  = (IC_BYTES > DC_BYTES) ? IC_BYTES : DC_BYTES;
    localparam int CNT_W = $clog2(MAXB + 1);

    typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} state_t;

    state_t                      r_state, w_next;
    logic [RAM_ADDR_W-1:0]       r_base;
    logic [CNT_W-1:0]            r_len, r_iss, r_ncap, r_pidx;
    logic                        r_pend;     // a read byte was issued last cycle
    logic                        r_lg_dc;    // last grant went to DC
    logic [DC_BYTES*BYTE_W-1:0]  r_wdat;
    logic [MAXB*BYTE_W-1:0]      r_buf, w_buf;

    logic             w_ic_el, w_dc_el, w_grant_ic, w_grant_dc;
    logic             w_issue, w_rd_done, w_wr_done;
    logic [CNT_W-1:0] w_dc_len;
    logic             w_unused;

    // Only the low RAM_ADDR_W address bits reach the RAM.
    assign w_unused = ^{iIC_Add[ADDR_W-1:RAM_ADDR_W], iDC_Add[ADDR_W-1:RAM_ADDR_W]};

    // A port whose done pulse is high this cycle sits out arbitration, so a
    // still-asserted level request is not re-accepted.
    assign w_ic_el    = iIC_En && !oIC_En && !iIC_Clr;
    assign w_dc_el    = iDC_En && !oDC_En;
    assign w_grant_dc = en && w_dc_el && (!w_ic_el || !r_lg_dc);
    assign w_grant_ic = en && w_ic_el && !w_grant_dc;

    always_comb begin
        case (iDC_Len)
            2'd0:    w_dc_len = CNT_W'(1);
            2'd1:    w_dc_len = CNT_W'(2);
            default: w_dc_len = CNT_W'(DC_BYTES);
        endcase
    end

    assign w_issue   = en && (r_state != IDLE) && (r_iss < r_len);
    // Reads finish once every byte is captured, counting one landing this edge.
    assign w_rd_done = en && (((r_state == IC_RD) && !iIC_Clr) || (r_state == DC_RD))
                       && ((r_ncap + CNT_W'(r_pend)) == r_len);
    assign w_wr_done = (r_state == DC_WR) && w_issue && (r_iss == r_len - CNT_W'(1));

    // Merge the byte returning from RAM into the assembly buffer.
    always_comb begin
        w_buf = r_buf;
        if (r_pend)
            w_buf[int'(r_pidx)*BYTE_W +: BYTE_W] = iRAM_Dat;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_grant_dc)      w_next = iDC_Rw ? DC_RD : DC_WR;
                   else if (w_grant_ic) w_next = IC_RD;
            IC_RD: if (iIC_Clr || w_rd_done) w_next = IDLE;
            DC_RD: if (w_rd_done) w_next = IDLE;
            DC_WR: if (w_wr_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM-side outputs; address stays put while stalled since r_iss does not move.
    always_comb begin
        oBusy    = (r_state != IDLE);
        oRAM_Add = r_base + RAM_ADDR_W'(r_iss);
        oRAM_Rw  = !(w_issue && (r_state == DC_WR));
        oRAM_Dat = '0;
        if (w_issue && (r_state == DC_WR))
            oRAM_Dat = BYTE_W'(r_wdat >> (int'(r_iss) * BYTE_W));
    end

    // Datapath: transaction context, capture pipeline, completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_len   <= '0;
            r_iss   <= '0;
            r_ncap  <= '0;
            r_pidx  <= '0;
            r_pend  <= 1'b0;
            r_lg_dc <= 1'b0;
            r_wdat  <= '0;
            r_buf   <= '0;
            oIC_En  <= 1'b0;
            oDC_En  <= 1'b0;
            oIC_Dat <= '0;
            oDC_Dat <= '0;
        end else begin
            oIC_En <= 1'b0;
            oDC_En <= 1'b0;
            r_buf  <= w_buf;
            r_pend <= w_issue && (r_state != DC_WR);
            r_pidx <= r_iss;
            if (r_pend)  r_ncap <= r_ncap + CNT_W'(1);
            if (w_issue) r_iss  <= r_iss + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_grant_dc || w_grant_ic) begin
                        r_iss  <= '0;
                        r_ncap <= '0;
                        r_buf  <= '0;
                    end
                    if (w_grant_dc) begin
                        r_base <= iDC_Add[RAM_ADDR_W-1:0];
                        r_len  <= w_dc_len;
                        r_wdat <= iDC_Dat;
                    end else if (w_grant_ic) begin
                        r_base <= iIC_Add[RAM_ADDR_W-1:0];
                        r_len  <= CNT_W'(IC_BYTES);
                    end
                end
                IC_RD: begin
                    if (iIC_Clr) begin
                        r_pend <= 1'b0;      // drop any byte still in flight
                    end else if (w_rd_done) begin
                        oIC_En  <= 1'b1;
                        oIC_Dat <= w_buf[IC_BYTES*BYTE_W-1:0];
                        r_lg_dc <= 1'b0;
                    end
                end
                DC_RD: begin
                    if (w_rd_done) begin
                        oDC_En  <= 1'b1;
                        oDC_Dat <= w_buf[DC_BYTES*BYTE_W-1:0];
                        r_lg_dc <= 1'b1;
                    end
                end
                DC_WR: begin
                    if (w_wr_done) begin
                        oDC_En  <= 1'b1;
                        r_lg_dc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
module tb_mem_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        iIC_En, iIC_Clr, oIC_En;
    logic [31:0] iIC_Add, oIC_Dat;
    logic        iDC_En, iDC_Rw, oDC_En;
    logic [1:0]  iDC_Len;
    logic [31:0] iDC_Add, iDC_Dat, oDC_Dat;
    logic        oRAM_Rw;
    logic [16:0] oRAM_Add;
    logic [7:0]  oRAM_Dat, iRAM_Dat;
    logic        oBusy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:131071];

    mem_arb_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .iIC_En(iIC_En), .iIC_Add(iIC_Add), .iIC_Clr(iIC_Clr),
        .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
        .iDC_En(iDC_En), .iDC_Rw(iDC_Rw), .iDC_Len(iDC_Len),
        .iDC_Add(iDC_Add), .iDC_Dat(iDC_Dat),
        .oDC_En(oDC_En), .oDC_Dat(oDC_Dat),
        .oRAM_Rw(oRAM_Rw), .oRAM_Add(oRAM_Add), .oRAM_Dat(oRAM_Dat),
        .iRAM_Dat(iRAM_Dat), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data valid one cycle after the address.
    always @(posedge clk) begin
        if (!oRAM_Rw) mem[oRAM_Add] <= oRAM_Dat;
        iRAM_Dat <= mem[oRAM_Add];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] wd;
        logic [16:0] wa [4];
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem['h100] = 8'h13; mem['h101] = 8'h05; mem['h102] = 8'h10; mem['h103] = 8'h00;
        mem['h1FFFE] = 8'h11; mem['h1FFFF] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        iRAM_Dat = 8'h00;

        rst = 1'b1; en = 1'b1;
        iIC_En = 0; iIC_Add = 0; iIC_Clr = 0;
        iDC_En = 0; iDC_Rw = 1; iDC_Len = 0; iDC_Add = 0; iDC_Dat = 0;
        step(); step();
        chk("rst_busy",  oBusy, 0);
        chk("rst_rw",    oRAM_Rw, 1);
        chk("rst_add",   oRAM_Add, 0);
        chk("rst_rdat",  oRAM_Dat, 0);
        chk("rst_icen",  oIC_En, 0);
        chk("rst_dcen",  oDC_En, 0);
        chk("rst_icdat", oIC_Dat, 0);
        chk("rst_dcdat", oDC_Dat, 0);
        rst = 1'b0;

        // IC fetch of 0x100
        iIC_Add = 32'h100; iIC_En = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("icA_add", oRAM_Add, 17'h100 + 17'(k));
            chk("icA_rw", oRAM_Rw, 1);
            step();
        end
        chk("icA_early", oIC_En, 0);
        step();
        chk("icA_done", oIC_En, 1);
        chk("icA_dat", oIC_Dat, 32'h00100513);
        iIC_En = 0;
        step();
        chk("icA_pulse", oIC_En, 0);

        // DC write of 4 bytes at 0x200
        wd = 32'hDEADBEEF;
        iDC_En = 1; iDC_Rw = 0; iDC_Len = 2; iDC_Add = 32'h200; iDC_Dat = wd;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("dcW_rw", oRAM_Rw, 0);
            chk("dcW_add", oRAM_Add, 17'h200 + 17'(k));
            chk("dcW_dat", oRAM_Dat, wd[8*k +: 8]);
            chk("dcW_early", oDC_En, 0);
            step();
        end
        chk("dcW_done", oDC_En, 1);
        iDC_En = 0;
        step();

        // DC 1-byte read of 0x202
        iDC_En = 1; iDC_Rw = 1; iDC_Len = 0; iDC_Add = 32'h202;
        step();
        chk("dcR_add", oRAM_Add, 17'h202);
        step();
        chk("dcR_early", oDC_En, 0);
        step();
        chk("dcR_done", oDC_En, 1);
        chk("dcR_dat", oDC_Dat, 32'h000000AD);
        iDC_En = 0;
        step();

        // Arbitration out of reset: DC, IC, DC, then a fresh tie goes to IC
        rst = 1'b1; step(); rst = 1'b0;
        iIC_En = 1; iIC_Add = 32'h100;
        iDC_En = 1; iDC_Rw = 1; iDC_Len = 0; iDC_Add = 32'h202;
        step();
        chk("arb1_dc", oRAM_Add, 17'h202);
        step(); step();
        chk("arb1_done", oDC_En, 1);
        step();
        chk("arb2_ic", oRAM_Add, 17'h100);
        chk("arb2_busy", oBusy, 1);
        repeat (5) step();
        chk("arb2_done", oIC_En, 1);
        chk("arb2_dat", oIC_Dat, 32'h00100513);
        step();
        chk("arb3_dc", oRAM_Add, 17'h202);
        iIC_En = 0;
        step(); step();
        chk("arb3_done", oDC_En, 1);
        iDC_En = 0;
        step();
        iIC_En = 1; iDC_En = 1;
        step();
        chk("arb4_ic", oRAM_Add, 17'h100);
        iDC_En = 0;
        repeat (5) step();
        chk("arb4_done", oIC_En, 1);
        iIC_En = 0;
        step();

        // Address wrap at the top of RAM
        wa[0] = 17'h1FFFE; wa[1] = 17'h1FFFF; wa[2] = 17'h00000; wa[3] = 17'h00001;
        iIC_Add = 32'h0001FFFE; iIC_En = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("wrap_add", oRAM_Add, wa[k]);
            step();
        end
        step();
        chk("wrap_done", oIC_En, 1);
        chk("wrap_dat", oIC_Dat, 32'h44332211);
        iIC_En = 0;
        step();

        // Stall for 3 cycles while byte 1 of a 4-byte read is due
        iIC_Add = 32'h200; iIC_En = 1;
        step();
        chk("stall_a0", oRAM_Add, 17'h200);
        step();
        repeat (3) begin
            en = 0;
            #1;
            chk("stall_hold", oRAM_Add, 17'h201);
            chk("stall_rw", oRAM_Rw, 1);
            step();
        end
        en = 1;
        chk("stall_a1", oRAM_Add, 17'h201);
        step();
        chk("stall_a2", oRAM_Add, 17'h202);
        step();
        chk("stall_a3", oRAM_Add, 17'h203);
        step();
        chk("stall_early", oIC_En, 0);
        step();
        chk("stall_done", oIC_En, 1);
        chk("stall_dat", oIC_Dat, 32'hDEADBEEF);
        iIC_En = 0;
        step();

        // Fetch abort with a DC read waiting
        iIC_Add = 32'h100; iIC_En = 1;
        step();
        iDC_En = 1; iDC_Rw = 1; iDC_Len = 1; iDC_Add = 32'h200;
        chk("clr_a0", oRAM_Add, 17'h100);
        step(); step();
        chk("clr_a2", oRAM_Add, 17'h102);
        iIC_Clr = 1; iIC_En = 0;
        step();
        chk("clr_idle", oBusy, 0);
        chk("clr_noen", oIC_En, 0);
        chk("clr_hold", oIC_Dat, 32'hDEADBEEF);
        iIC_Clr = 0;
        step();
        chk("clr_dc", oRAM_Add, 17'h200);
        chk("clr_dcbusy", oBusy, 1);
        step(); step();
        chk("clr_dcearly", oDC_En, 0);
        chk("clr_noen2", oIC_En, 0);
        step();
        chk("clr_dcdone", oDC_En, 1);
        chk("clr_dcdat", oDC_Dat, 32'h0000BEEF);
        iDC_En = 0;
        step();

        // Reset in the middle of a DC write
        iDC_En = 1; iDC_Rw = 0; iDC_Len = 1; iDC_Add = 32'h300; iDC_Dat = 32'h1234;
        step();
        chk("rstw_rw0", oRAM_Rw, 0);
        rst = 1'b1;
        #1;
        chk("rstw_rw1", oRAM_Rw, 1);
        chk("rstw_busy", oBusy, 0);
        iDC_En = 0;
        step();
        rst = 1'b0;
        chk("rstw_noen", oDC_En, 0);
        chk("rstw_dat", oDC_Dat, 0);
        step();
        chk("rstw_noen2", oDC_En, 0);
        chk("rstw_idle", oBusy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
- Parametrised successor to the single-port memory controller.
- Arbitrates an instruction-fetch port (IC) and a data port (DC) onto one byte-wide synchronous RAM.
- Sequences multi-byte little-endian reads and writes, one byte per cycle.
- Sits between the IC/DC caches and the top-level RAM/IO bus; supports data-side writes, variable access size, round-robin arbitration, fetch abort and a global stall.

Parameters:
- ADDR_W, 32, width of IC/DC byte addresses.
- RAM_ADDR_W, 17, width of RAM address bus (lower bits of computed address).
- BYTE_W, 8, RAM data width.
- IC_BYTES, 4, bytes per instruction fetch (1..8); oIC_Dat width = IC_BYTES*BYTE_W.
- DC_BYTES, 4, max bytes per data access; oDC_Dat/iDC_Dat width = DC_BYTES*BYTE_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; 0 = stall.
- iIC_En  in  1  fetch request, level, held until oIC_En.
- iIC_Add  in  ADDR_W  fetch base address.
- iIC_Clr  in  1  abort outstanding/pending fetch.
- oIC_En  out  1  fetch done, 1-cycle pulse.
- oIC_Dat  out  IC_BYTES*BYTE_W  fetched bytes; byte k at [8k+7:8k].
- iDC_En  in  1  data request, level, held until oDC_En.
- iDC_Rw  in  1  1 = read, 0 = write.
- iDC_Len  in  2  0 = 1B, 1 = 2B, 2 or 3 = DC_BYTES.
- iDC_Add  in  ADDR_W  data base address.
- iDC_Dat  in  DC_BYTES*BYTE_W  write data, byte k at [8k+7:8k].
- oDC_En  out  1  data done, 1-cycle pulse (reads and writes).
- oDC_Dat  out  DC_BYTES*BYTE_W  read data, zero-extended above length.
- oRAM_Rw  out  1  1 = read, 0 = write.
- oRAM_Add  out  RAM_ADDR_W  RAM byte address.
- oRAM_Dat  out  BYTE_W  RAM write byte.
- iRAM_Dat  in  BYTE_W  RAM read byte, valid one cycle after address.
- oBusy  out  1  1 when state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, oIC_En=0, oDC_En=0, oIC_Dat=0, oDC_Dat=0, oRAM_Rw=1, oRAM_Add=0, oRAM_Dat=0, last_grant=IC (so DC wins first tie). Reset mid-transaction drops it with no done pulse.
- FSM states: IDLE, IC_RD, DC_RD, DC_WR.
- IDLE accept, requires en=1. A port is not eligible in a cycle where its own done pulse is high.
  - Both eligible: grant the port not in last_grant.
  - Accept latches base address, length L (IC: IC_BYTES; DC: decoded iDC_Len), write data and direction; issue counter = 0.
  - No RAM access in the accept cycle.
- Issue, cycles c0..c(L-1) after accept, only when en=1:
  - oRAM_Add = (base + issue_cnt) truncated to RAM_ADDR_W; this wraps 0x1FFFF -> 0x00000.
  - Read: oRAM_Rw=1. Write: oRAM_Rw=0, oRAM_Dat = byte issue_cnt.
  - issue_cnt increments per issued byte.
  - en=0: no issue, oRAM_Rw=1, address held.
- Read capture: a byte issued in cycle c is captured from iRAM_Dat at the end of cycle c+1 into byte slot k. Capture happens even if en=0 in c+1.
- Completion:
  - Read: at the edge capturing byte L-1, if en=1, assert that port's done for one cycle, load the assembled data, set last_grant, go to IDLE. Otherwise defer to the first edge with en=1.
  - Write: done asserted at the edge ending the last issue cycle.
  - Latency at en=1: read = L+1 cycles accept-to-done, write = L cycles.
- oIC_Dat/oDC_Dat hold their value until the next completion on that port; unused upper DC bytes = 0.
- iIC_Clr=1:
  - In IC_RD: go to IDLE at the next edge (regardless of en); outstanding capture discarded; no oIC_En.
  - In IDLE: IC is not eligible that cycle.
  - No effect on DC transactions.
- The requester must hold inputs stable until done; changes after accept are ignored.

Test Plan:
- IC fetch of 0x00000100, RAM bytes 0x13,0x05,0x10,0x00, en=1 -> 5 cycles after accept: oIC_En pulse, oIC_Dat=0x00100513, RAM addresses 0x100..0x103 with Rw=1.
- DC write Len=2, Add=0x00000200, Dat=0xDEADBEEF -> four consecutive cycles with Rw=0, Add 0x200..0x203, Dat EF,BE,AD,DE; oDC_En 4 cycles after accept; DC read Len=0 of 0x202 -> oDC_Dat=0x000000AD.
- iIC_En and iDC_En asserted together out of reset -> DC granted first; IC next; repeated simultaneous requests alternate DC, IC, DC.
- IC fetch at 0x0001FFFE -> oRAM_Add sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- en dropped 3 cycles during issue of byte 1 of a 4-byte read -> no duplicate or skipped address; correct word; done delayed exactly 3 cycles.
- iIC_Clr pulsed during IC_RD byte 2 -> IDLE next edge, no oIC_En, oIC_Dat unchanged; pending DC granted next cycle. rst asserted mid-DC-write -> oRAM_Rw=1 immediately, no oDC_En.
